// File: rtl/node_pkg.sv
// Shared types and constants for the interconnect node input arbiter:
// channel source encodings, arbiter FSM states and round-robin helper.
package node_pkg;

  localparam int unsigned NODE_DATA_W = 32;
  localparam int unsigned SRC_W       = 2;
  localparam int unsigned DROP_CNT_W  = 8;

  typedef enum logic [SRC_W-1:0] {
    SRC_SELF  = 2'd0,
    SRC_LEFT  = 2'd1,
    SRC_RIGHT = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ISSUE  = 2'd1,
    ARB_RETIRE = 2'd2
  } arb_state_e;

  // Cyclic order left -> right -> self -> left.
  function automatic src_e rr_next(input src_e s);
    case (s)
      SRC_LEFT:  return SRC_RIGHT;
      SRC_RIGHT: return SRC_SELF;
      default:   return SRC_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/node_input_slot.sv
// Single-entry holding slot for one shift-in channel: captures on strobe when
// free or retiring, drops strobes that hit an occupied slot.
module node_input_slot
  import node_pkg::*;
#(
  parameter int unsigned DATA_W = NODE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [DATA_W-1:0] data_in,
  input  logic              retire,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              drop
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_c;

  // A write on the retire cycle re-arms the slot instead of clearing it.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    write_c = cs & (~valid_q | retire);
    if (retire) begin
      valid_d = 1'b0;
    end
    if (write_c) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;
  assign busy     = valid_q & ~retire;
  assign drop     = cs & valid_q & ~retire;

endmodule

// File: rtl/node_input_arbiter.sv
// Round-robin arbiter feeding the node controller from the left, right and self
// shift-in slots. Optional drop counter enabled by NODE_ARB_DROP_CNT_EN.
module node_input_arbiter
  import node_pkg::*;
#(
  parameter int unsigned DATA_W = NODE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] shiftInLeftData,
  input  logic              shiftInLeftCS,
  input  logic [DATA_W-1:0] shiftInRightData,
  input  logic              shiftInRightCS,
  input  logic [DATA_W-1:0] shiftInData,
  input  logic              shiftInCS,
  input  logic              ctrlReady,
  output logic [DATA_W-1:0] instruction,
  output logic [1:0]        dataSource,
  output logic              controllerEn,
  output logic              busyLeft,
  output logic              busyRight,
  output logic              busySelf,
  output logic              overflow
`ifdef NODE_ARB_DROP_CNT_EN
  ,
  output logic [7:0]        dropCount
`endif
);

  logic [2:0]        slot_valid;
  logic [DATA_W-1:0] slot_data [3];
  logic [2:0]        retire_c;
  logic [2:0]        drop_c;

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  src_e              src_q, src_d;
  src_e              last_q, last_d;
  logic              en_q, en_d;
  logic              overflow_q, overflow_d;
  src_e              win_c;
  src_e              cand_c;
  logic              found_c;

  node_input_slot #(.DATA_W(DATA_W)) u_slot_left (
    .clk(clk), .reset(reset), .cs(shiftInLeftCS), .data_in(shiftInLeftData),
    .retire(retire_c[SRC_LEFT]), .valid(slot_valid[SRC_LEFT]),
    .data_out(slot_data[SRC_LEFT]), .busy(busyLeft), .drop(drop_c[SRC_LEFT])
  );

  node_input_slot #(.DATA_W(DATA_W)) u_slot_right (
    .clk(clk), .reset(reset), .cs(shiftInRightCS), .data_in(shiftInRightData),
    .retire(retire_c[SRC_RIGHT]), .valid(slot_valid[SRC_RIGHT]),
    .data_out(slot_data[SRC_RIGHT]), .busy(busyRight), .drop(drop_c[SRC_RIGHT])
  );

  node_input_slot #(.DATA_W(DATA_W)) u_slot_self (
    .clk(clk), .reset(reset), .cs(shiftInCS), .data_in(shiftInData),
    .retire(retire_c[SRC_SELF]), .valid(slot_valid[SRC_SELF]),
    .data_out(slot_data[SRC_SELF]), .busy(busySelf), .drop(drop_c[SRC_SELF])
  );

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    cand_c  = rr_next(last_q);
    win_c   = cand_c;
    found_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found_c && slot_valid[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
      cand_c = rr_next(cand_c);
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    src_d    = src_q;
    last_d   = last_q;
    en_d     = en_q;
    retire_c = 3'b000;
    case (state_q)
      ARB_IDLE: begin
        if (|slot_valid) begin
          instr_d = slot_data[win_c];
          src_d   = win_c;
          en_d    = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (ctrlReady) begin
          retire_c[src_q] = 1'b1;
          last_d          = src_q;
          en_d            = 1'b0;
          state_d         = ARB_RETIRE;
        end
      end
      ARB_RETIRE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign overflow_d = overflow_q | (|drop_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      instr_q    <= '0;
      src_q      <= SRC_SELF;
      last_q     <= SRC_SELF;
      en_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      src_q      <= src_d;
      last_q     <= last_d;
      en_q       <= en_d;
      overflow_q <= overflow_d;
    end
  end

  assign instruction  = instr_q;
  assign dataSource   = src_q;
  assign controllerEn = en_q;
  assign overflow     = overflow_q;

`ifdef NODE_ARB_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum_c;

  // Drops on several channels in one cycle add together, saturating.
  always_comb begin
    drop_sum_c = (DROP_CNT_W+1)'(drop_cnt_q) + (DROP_CNT_W+1)'(drop_c[0])
               + (DROP_CNT_W+1)'(drop_c[1]) + (DROP_CNT_W+1)'(drop_c[2]);
    drop_cnt_d = drop_sum_c[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum_c[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dropCount = drop_cnt_q;
`endif

endmodule

// File: doc/node_input_arbiter.md
# node_input_arbiter

Arbitration and sequencing front end for the one-dimensional interconnect node's instruction controller. Captures 32-bit words arriving on the left, right and self shift-in channels into one holding slot per channel. Grants the single node controller to one channel at a time in round-robin order, drives `dataSource`, `instruction` and `controllerEn`, and retires the word on the controller's ready handshake. Back-pressure and overflow are reported per channel.

## Interface
- `DATA_W`, 32, word width of every shift-in channel and of `instruction`
- `clk` input 1: single system clock, rising-edge
- `reset` input 1: asynchronous, active-high
- `shiftInLeftData` / `shiftInLeftCS` input 32/1: left-neighbour word and one-cycle capture strobe
- `shiftInRightData` / `shiftInRightCS` input 32/1: right-neighbour word and strobe
- `shiftInData` / `shiftInCS` input 32/1: local (self) word and strobe
- `ctrlReady` input 1: controller accepts the presented instruction this cycle
- `instruction` output 32: word granted to the controller
- `dataSource` output 2: granted channel; 2'd0 self, 2'd1 left, 2'd2 right, 2'd3 never driven
- `controllerEn` output 1: `instruction`/`dataSource` valid
- `busyLeft`, `busyRight`, `busySelf` output 1 each: slot occupied and not retiring this cycle
- `overflow` output 1: sticky; a strobe hit an occupied slot
- `dropCount` output 8: present only with `NODE_ARB_DROP_CNT_EN`

## Operation
- Per-channel slot: `valid` bit plus 32-bit data. A strobe while the slot is free, or on the retire handshake of that same slot, writes the data and sets `valid`.
- A strobe while busy is dropped. The stored word is kept and `overflow` is set until reset.
- FSM with three states:
  - IDLE: when any slot is valid, register the round-robin winner's data and channel, then go to ISSUE.
  - ISSUE: `controllerEn`=1 with stable `instruction`/`dataSource`. When `ctrlReady`=1, clear the winner's `valid` (unless rewritten the same cycle), set `lastGrant` to the winner, and go to RETIRE.
  - RETIRE: one gap cycle with `controllerEn`=0, then IDLE.
- Round-robin cyclic order is left → right → self. Search starts at the channel after `lastGrant`. `lastGrant` resets to self, so left has first priority.
- Slots that become valid while in ISSUE or RETIRE do not disturb the current grant.

## Timing
- Strobe sampled at edge N; slot valid after N; `controllerEn` high after N+1, so minimum latency is 2 cycles.
- A handshake at edge M drops `controllerEn` after M. The next grant's `controllerEn` rises after M+2, giving a 3-cycle issue period at `ctrlReady`=1.
- `busy*` is combinational from slot valid and the handshake. Senders may strobe in a cycle where `busy*`=0.
- Reset values: `instruction`=0, `dataSource`=0, `controllerEn`=0, all `busy*`=0, `overflow`=0, `dropCount`=0, state IDLE, `lastGrant`=self, all slots invalid.
- Reset mid-ISSUE abandons the grant immediately; no retire occurs.
- `ctrlReady` is ignored outside ISSUE.

## Configuration
- `NODE_ARB_DROP_CNT_EN` defined: `dropCount` port exists and increments on each dropped strobe, saturating at 8'hFF.
- Simultaneous drops on multiple channels in one cycle add their count, still saturating.
- Undefined: no port and no counter logic; `overflow` behaviour is unchanged.

## Structure
- Shared package `node_pkg`:
  - source encodings `SRC_SELF`/`SRC_LEFT`/`SRC_RIGHT`
  - FSM state enum `ARB_IDLE`/`ARB_ISSUE`/`ARB_RETIRE`
  - `DATA_W` default
- One sub-module, `node_input_slot`, instantiated three times. It holds the single-entry buffer with strobe/retire logic and its busy and drop outputs.

## Test plan
- Right strobe, data 32'hC4000000, `ctrlReady`=1: `controllerEn` high 2 cycles later with `dataSource`=2, `instruction`=32'hC4000000. Retires in 1 cycle and `busyRight` clears.
- Left 32'd73 and self 32'hC4000000 strobed in the same cycle, `ctrlReady`=1: left issued first, then self 3 cycles later. `lastGrant` ends as self.
- `ctrlReady`=0 for 10 cycles during ISSUE: `controllerEn`, `instruction` and `dataSource` stay stable. A second right strobe in that window sets `overflow`, increments `dropCount` to 1 with the macro, and leaves the original word to be issued.
- All three channels strobed continuously on every free cycle: grants rotate left, right, self, left and never repeat back-to-back.
- Reset asserted during ISSUE with all slots full: all outputs are 0 on the same cycle. After release, a single self strobe of 32'h80000000 issues with `dataSource`=0.
